// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with a single sign-fix cycle at the end.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      muldiv_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic            neg_a_q, neg_b_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, lo_q, b_q;
    logic [XLEN-1:0] acc_nxt, lo_nxt;

    logic            accepting, accept;
    logic            sign_a, sign_b, in_neg_a, in_neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res, fix_res;

    // ---------------- acceptance decode ----------------
    always_comb begin
        accepting = (state_q == S_IDLE) || (state_q == S_DONE);
        accept    = accepting && start && !flush;

        sign_a = (muldiv_op == OP_MULH) || (muldiv_op == OP_MULHSU) ||
                 (muldiv_op == OP_DIV)  || (muldiv_op == OP_REM);
        sign_b = (muldiv_op == OP_MULH) || (muldiv_op == OP_DIV) ||
                 (muldiv_op == OP_REM);
        in_neg_a = sign_a && rs1[XLEN-1];
        in_neg_b = sign_b && rs2[XLEN-1];
        mag_a    = in_neg_a ? -rs1 : rs1;
        mag_b    = in_neg_b ? -rs2 : rs2;

        div_zero = muldiv_op[2] && (rs2 == '0);
        div_ovf  = ((muldiv_op == OP_DIV) || (muldiv_op == OP_REM)) &&
                   (rs1 == MIN_INT) && (rs2 == '1);
        fast     = div_zero || div_ovf;

        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            fast_res = muldiv_op[1] ? rs1 : '1;
        end else begin
            fast_res = muldiv_op[1] ? '0 : rs1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = fast ? S_DONE : S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC:  state_d = (cnt_q == LAST) ? S_FIX : S_CALC;
                S_FIX:   state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

    // ---------------- one iteration of the shared datapath ----------------
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum, shifted, diff;

    always_comb begin
        addend  = lo_q[0] ? b_q : '0;
        sum     = {1'b0, acc_q} + {1'b0, addend};
        shifted = {acc_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        acc_nxt = acc_q;
        lo_nxt  = lo_q;
        if (op_q[2]) begin
            // restoring divide: keep the trial subtraction only if it did not borrow
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                lo_nxt  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[XLEN-1:0];
                lo_nxt  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[XLEN:1];
            lo_nxt  = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
        end else if (accept) begin
            op_q    <= muldiv_op;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            cnt_q   <= '0;
            acc_q   <= '0;
            if (muldiv_op[2]) begin
                lo_q <= mag_a;
                b_q  <= mag_b;
            end else begin
                lo_q <= mag_b;
                b_q  <= mag_a;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_nxt;
            lo_q  <= lo_nxt;
        end
    end

    // ---------------- sign fix and result register ----------------
    logic [2*XLEN-1:0] full, prod;
    logic [XLEN-1:0]   quot, rem;

    always_comb begin
        full = {acc_q, lo_q};
        prod = (neg_a_q ^ neg_b_q) ? -full : full;
        quot = ((op_q == OP_DIV) && (neg_a_q ^ neg_b_q)) ? -lo_q : lo_q;
        rem  = ((op_q == OP_REM) && neg_a_q) ? -acc_q : acc_q;
        case (op_q)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quot;
            OP_REM, OP_REMU:              fix_res = rem;
            default:                      fix_res = '0;
        endcase
    end

    // result only moves on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (accept && fast) begin
            result <= fast_res;
        end else if ((state_q == S_FIX) && !flush) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for flush, reset and back-to-back.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;
    localparam int NORM_LAT = XLEN + 2;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  muldiv_op;
    logic [31:0] rs1, rs2, result;
    logic        busy, done;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .muldiv_op(muldiv_op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: products computed exactly in 64 bits, divides with SV signed/unsigned operators.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return MIN_INT;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Presents one request for one cycle, then scrambles the inputs while the op is in flight.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        muldiv_op = op;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        step();
        start = 1'b0;
        muldiv_op = 3'($urandom);
        rs1 = $urandom;
        rs2 = $urandom;
    endtask

    task automatic wait_done(input int first, output int lat, output bit busy_ok);
        lat = first;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit busy_ok;
        exp_q.push_back(exp);
        start_op(op, a, b);
        wait_done(1, lat, busy_ok);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
        check({name, "_result"}, result, exp_q.pop_front());
        held_res = exp;
        step();
        check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({name, "_result_hold"}, result, exp);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        bit quiet;
        logic [2:0] op;
        logic [31:0] a, b, e;

        vecs[0]  = '{"mul_7_neg3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{"mulh_min_min",   3'd1, MIN_INT,      MIN_INT,       32'h4000_0000, 34};
        vecs[2]  = '{"mulhu_ones",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{"mulhsu_ones",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{"div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34};
        vecs[5]  = '{"rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34};
        vecs[6]  = '{"div_by_zero",    3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1};
        vecs[7]  = '{"remu_by_zero",   3'd7, 32'd5,        32'd0,        32'd5,         1};
        vecs[8]  = '{"div_overflow",   3'd4, MIN_INT,      32'hFFFF_FFFF, MIN_INT,       1};
        vecs[9]  = '{"rem_overflow",   3'd6, MIN_INT,      32'hFFFF_FFFF, 32'd0,         1};
        vecs[10] = '{"divu_big",       3'd5, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 34};
        vecs[11] = '{"remu_100_7",     3'd7, 32'd100,      32'd7,        32'd2,         34};
        vecs[12] = '{"mulh_m1_7",      3'd1, 32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFFF, 34};
        vecs[13] = '{"divu_min_ones",  3'd5, MIN_INT,      32'hFFFF_FFFF, 32'd0,         34};
        vecs[14] = '{"rem_7_m2",       3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,         34};
        vecs[15] = '{"mulhu_min_2",    3'd3, MIN_INT,      32'd2,        32'd1,         34};

        // ---------------- clock / reset ----------------
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        muldiv_op = '0;
        rs1 = '0;
        rs2 = '0;
        held_res = '0;
        repeat (3) step();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // ---------------- randomized against the reference model ----------------
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
            run_vec("rand", op, a, b, model(op, a, b), model_lat(op, a, b));
        end

        // ---------------- flush mid-MUL ----------------
        start_op(3'd0, 32'd1234, 32'd5678);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_next", {31'b0, busy}, 32'd0);
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            step();
        end
        check("flush_no_done", {31'b0, quiet}, 32'd1);
        check("flush_result_kept", result, held_res);

        // ---------------- flush beats start in the same cycle ----------------
        muldiv_op = 3'd0;
        rs1 = 32'd3;
        rs2 = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("flush_over_start", {30'b0, busy, done}, 32'd0);

        // ---------------- back-to-back ----------------
        start_op(3'd5, 32'd1000, 32'd10);
        wait_done(1, lat, busy_ok);
        check("b2b_first_lat", 32'(lat), 32'd34);
        check("b2b_first_result", result, 32'd100);
        start_op(3'd0, 32'd6, 32'd7);
        check("b2b_second_busy", {31'b0, busy}, 32'd1);
        wait_done(1, lat, busy_ok);
        check("b2b_second_lat", 32'(lat), 32'd34);
        check("b2b_second_busy_ok", {31'b0, busy_ok}, 32'd1);
        check("b2b_second_result", result, 32'd42);
        step();

        // ---------------- reset mid-DIV, then immediate acceptance ----------------
        start_op(3'd4, 32'd1000, 32'd7);
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        run_vec("after_reset", 3'd4, 32'd1000, 32'd7, 32'd142, 34);

        // ---------------- start while busy is ignored ----------------
        start_op(3'd0, 32'd123, 32'd456);
        repeat (4) step();
        muldiv_op = 3'd4;
        rs1 = 32'd9;
        rs2 = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(6, lat, busy_ok);
        check("ign_start_lat", 32'(lat), 32'd34);
        check("ign_start_result", result, 32'd56088);
        step();
        quiet = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            step();
        end
        check("ign_start_no_queue", {31'b0, quiet}, 32'd1);
        check("ign_start_result_hold", result, 32'd56088);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
